// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; base ops in one cycle, iterative unsigned mul/div/rem
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero,
    output logic             busy
);
    localparam int CNTW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, nstate;
    logic [CNTW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] opnd, alu, mag, shl, srl, sra;
    logic signed [WIDTH-1:0] asr;
    logic [WIDTH:0] msum, dshift, ddiff;
    logic sel_hi, accept, ext, dz, last, rsh, big;
    assign accept = in_valid && in_ready;
    assign ext = op[5];
    assign dz = op[1] && b == '0;
    assign last = cnt == CNTW'(WIDTH - 1);
    assign busy = state == MUL || state == DIV;
    assign in_ready = state == IDLE && (!out_valid || out_ready);
    // positive signed b shifts right by b, otherwise left by -b
    assign rsh = !b[WIDTH-1] && b != '0;
    assign mag = rsh ? b : -b;
    assign big = mag >= WIDTH'(WIDTH);
    assign asr = $signed(a) >>> mag;
    assign shl = big ? '0 : a << mag;
    assign srl = big ? '0 : a >> mag;
    assign sra = big ? {WIDTH{a[WIDTH-1]}} : asr;
    always_comb begin
        case (op[4:0])
            5'd0, 5'd11, 5'd26: alu = a + b;
            5'd1:               alu = a - b;
            5'd2, 5'd12:        alu = a & b;
            5'd3, 5'd13:        alu = a | b;
            5'd4, 5'd14:        alu = a ^ b;
            5'd5, 5'd15:        alu = rsh ? srl : shl;
            5'd6, 5'd16:        alu = rsh ? sra : shl;
            5'd7, 5'd17:        alu = WIDTH'(a < b);
            5'd8, 5'd18:        alu = WIDTH'($signed(a) < $signed(b));
            5'd9, 5'd19, 5'd24: alu = WIDTH'(a == b);
            5'd10, 5'd20, 5'd23: alu = WIDTH'(a != b);
            default:            alu = a;
        endcase
    end
    // mul: high half accumulates, low half shifts out multiplier bits
    // div: high half is the partial remainder, low half dividend turning into quotient
    assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign dshift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ddiff = dshift - {1'b0, opnd};
    assign acc_nx = state == MUL ? {msum, acc[WIDTH-1:1]}
                  : {ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0], acc[WIDTH-2:0], !ddiff[WIDTH]};
    always_comb begin
        nstate = state;
        case (state)
            IDLE:     if (accept && ext && !dz) nstate = op[1] ? DIV : MUL;
            MUL, DIV: if (last) nstate = DONE;
            default:  nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nstate;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result <= '0;
            div_zero <= 1'b0;
            acc <= '0;
            opnd <= '0;
            cnt <= '0;
            sel_hi <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept && (!ext || dz)) begin
                out_valid <= 1'b1;
                result <= !ext ? alu : op[0] ? a : '1;
                div_zero <= ext;
            end
            if (accept && ext && !dz) begin
                acc <= {{WIDTH{1'b0}}, op[1] ? a : b};
                opnd <= op[1] ? b : a;
                sel_hi <= op[0];
                cnt <= '0;
            end
            if (busy) begin
                acc <= acc_nx;
                cnt <= cnt + CNTW'(1);
                if (last) begin
                    out_valid <= 1'b1;
                    result <= sel_hi ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
                    div_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the CPU's combinational ALU.
- Executes the full 5-bit base ALU op set with a 1-cycle registered latency.
- Adds iterative unsigned multiply and divide/remainder units, selected by a 6th op bit.
- Sits between decode/regfile read and writeback. Valid/ready on both sides lets the pipeline stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand and result width in bits (≥8).
- CNTW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept an op this cycle.
- op  in  6  op[5]=0: base op code op[4:0]; op[5]=1: extended op op[1:0].
- a  in  WIDTH  first operand (reg1).
- b  in  WIDTH  second operand (reg2/immediate).
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- div_zero  out  1  qualifies result: DIVU/REMU had b==0.
- busy  out  1  iterative unit running.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, div_zero=0, busy=0, counter=0. Reset mid-iteration aborts the op; no result is produced.
- Transfer: in takes place when in_valid&&in_ready; out takes place when out_valid&&out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives back-to-back base ops at full rate.
- While out_valid=1 and out_ready=0: result and div_zero hold stable.

Base ops (op[5]=0), result registered, out_valid on the cycle after accept:
- 0/11 and 26: a+b.
- 1: a-b.
- 2/12: a&b.
- 3/13: a|b.
- 4/14: a^b.
- 5/15 (logical shift): signed b > 0 shifts a right logically by b. b ≤ 0 shifts left by -b. Magnitude ≥ WIDTH gives 0.
- 6/16 (arithmetic shift): as logical shift, but right shift fills with sign. Right magnitude ≥ WIDTH gives all sign bits; left magnitude ≥ WIDTH gives 0.
- 7/17: unsigned a<b, zero-extended.
- 8/18: signed a<b.
- 9/19 and 24: a==b.
- 10/20 and 23: a!=b.
- All other codes: pass a.
- Arithmetic wraps mod 2^WIDTH.

Extended ops (op[5]=1): op[1:0] 0=MUL (low WIDTH bits), 1=MULHU (high WIDTH bits), 2=DIVU, 3=REMU. All unsigned.

State machine: IDLE → MUL or DIV on accept of an extended op → DONE after WIDTH iterations → IDLE.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle.
- Latency: accept at cycle N, busy=1 on cycles N+1..N+WIDTH, out_valid=1 at cycle N+WIDTH+1.
- DONE loads result and returns to IDLE. The output-stall rules apply.
- DIVU/REMU with b==0: no iteration. Result is available on the next cycle (1-cycle latency), div_zero=1. DIVU returns all ones; REMU returns a.
- div_zero=0 for every other op.
- in_valid while busy: ignored (in_ready=0). Operands are captured at accept; later changes to a/b/op have no effect.

Test Plan:
- Reset: hold rst_n=0 mid-MUL, release → out_valid=0, busy=0, result=0, in_ready=1 next cycle.
- Base ops: ADD a=0xFFFFFFFF b=1 → 0 at next cycle. SLOG a=0x80000000 b=-4 → 0. SARI a=0x80000000 b=4 → 0xF8000000. ILT a=-1 b=0 → 1. ILTU a=-1 b=0 → 0.
- Streaming: 4 back-to-back ADDs with out_ready=1 → 4 results on consecutive cycles. Drop out_ready for 3 cycles → result held and in_ready=0 for those cycles.
- MUL/MULHU a=0xFFFFFFFF b=0xFFFFFFFF → 0x00000001 / 0xFFFFFFFE, out_valid exactly 33 cycles after accept, busy high 32 cycles.
- DIVU a=100 b=7 → 14; REMU → 2. Div-by-zero: DIVU a=5 b=0 → 0xFFFFFFFF div_zero=1 after 1 cycle; REMU → 5.
- Operand change during DIV and in_valid pulses while busy → ignored; result still matches the captured operands.
